// File: rtl/io_sequencer_if.sv
// Bundle of CPU-side request signals and external port handshakes for io_sequencer.
// The sequencer connects through the master modport. The CPU and the port models connect through the slave modport.
interface io_sequencer_if;
  logic        in_req;
  logic        out_req;
  logic [15:0] out_wdata;
  logic        stall;
  logic        done;
  logic [15:0] in_rdata;
  logic [15:0] ext_in_data;
  logic        ext_in_valid;
  logic        ext_in_ready;
  logic [15:0] ext_out_data;
  logic        ext_out_valid;
  logic        ext_out_ready;
  logic        io_err;

  modport master (
    input  in_req, out_req, out_wdata, ext_in_data, ext_in_valid, ext_out_ready,
    output stall, done, in_rdata, ext_in_ready, ext_out_data, ext_out_valid, io_err
  );

  modport slave (
    output in_req, out_req, out_wdata, ext_in_data, ext_in_valid, ext_out_ready,
    input  stall, done, in_rdata, ext_in_ready, ext_out_data, ext_out_valid, io_err
  );
endinterface

// File: rtl/io_sequencer.sv
// Multi-cycle IN/OUT sequencer. It stalls the pipeline while it handshakes with the switch and display ports.
// Optional wait timeout: define IO_SEQUENCER_TIMEOUT_EN.
module io_sequencer #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          reset,
  io_sequencer_if.master bus
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("io_sequencer: TIMEOUT must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_WAIT  = 2'd1,
    OUT_WAIT = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] in_rdata_q, in_rdata_d;
  logic [15:0] out_data_q, out_data_d;
  logic        io_err_q, io_err_d;
  logic        timeout_hit;

`ifdef IO_SEQUENCER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
  logic [15:0] wait_cnt_q, wait_cnt_d;
  assign timeout_hit = (wait_cnt_q == TIMEOUT_W);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every _d signal starts from its held value so that no path leaves it unassigned, which would infer a latch.
    state_d    = state_q;
    in_rdata_d = in_rdata_q;
    out_data_d = out_data_q;
    io_err_d   = io_err_q;
`ifdef IO_SEQUENCER_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef IO_SEQUENCER_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        // OUT wins a simultaneous request. The IN request is dropped, not queued.
        if (bus.out_req) begin
          out_data_d = bus.out_wdata;
          state_d    = OUT_WAIT;
        end else if (bus.in_req) begin
          state_d = IN_WAIT;
        end
      end
      IN_WAIT: begin
`ifdef IO_SEQUENCER_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q + 16'd1;
`endif
        if (bus.ext_in_valid) begin
          in_rdata_d = bus.ext_in_data;
          state_d    = DONE;
        end else if (timeout_hit) begin
          in_rdata_d = 16'h0000;
          io_err_d   = 1'b1;
          state_d    = DONE;
        end
      end
      OUT_WAIT: begin
`ifdef IO_SEQUENCER_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q + 16'd1;
`endif
        if (bus.ext_out_ready) begin
          state_d = DONE;
        end else if (timeout_hit) begin
          io_err_d = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so that every flop samples values from before the edge.
    if (reset) begin
      state_q    <= IDLE;
      in_rdata_q <= '0;
      out_data_q <= '0;
      io_err_q   <= 1'b0;
`ifdef IO_SEQUENCER_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      in_rdata_q <= in_rdata_d;
      out_data_q <= out_data_d;
      io_err_q   <= io_err_d;
`ifdef IO_SEQUENCER_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  // The port handshake outputs come only from state, so there is no combinational loop through the ext_* inputs.
  assign bus.ext_in_ready  = (state_q == IN_WAIT);
  assign bus.ext_out_valid = (state_q == OUT_WAIT);
  assign bus.done          = (state_q == DONE);
  assign bus.stall         = ((state_q == IDLE) && (bus.in_req || bus.out_req))
                           || (state_q == IN_WAIT) || (state_q == OUT_WAIT);
  assign bus.in_rdata      = in_rdata_q;
  assign bus.ext_out_data  = out_data_q;
  assign bus.io_err        = io_err_q;

endmodule

// File: tb/tb_io_sequencer.sv
// Directed self-checking bench for io_sequencer. The status nibble is {stall, done, ext_in_ready, ext_out_valid}.
module tb_io_sequencer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  io_sequencer_if bus ();

  io_sequencer #(.TIMEOUT(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] status();
    return {bus.stall, bus.done, bus.ext_in_ready, bus.ext_out_valid};
  endfunction

  // Inputs are driven 1 time unit after the rising edge. Outputs are sampled 2 time units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    settle();
    n_checks++;
    if (status() !== 4'b0000) begin
      n_fail++; $display("FAIL reset_status: got %b expected 0000", status());
    end
    n_checks++;
    if (bus.in_rdata !== 16'h0000 || bus.ext_out_data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_data: in_rdata=%h ext_out_data=%h expected 0000/0000", bus.in_rdata, bus.ext_out_data);
    end
    n_checks++;
    if (bus.io_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_io_err: got %b expected 0", bus.io_err);
    end
  endtask

  task automatic test_in_delayed();
    next_cycle();
    bus.in_req = 1'b1;
    bus.ext_in_data = 16'h1111;
    settle();
    n_checks++;
    if (status() !== 4'b1000) begin
      n_fail++; $display("FAIL in_delayed_c0: status=%b expected 1000", status());
    end
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      if (c == 4) begin
        bus.ext_in_valid = 1'b1;
        bus.ext_in_data  = 16'hBEEF;
      end
      settle();
      n_checks++;
      if (status() !== 4'b1010) begin
        n_fail++; $display("FAIL in_delayed_c%0d: status=%b expected 1010", c, status());
      end
    end
    next_cycle();
    bus.ext_in_valid = 1'b0;
    bus.ext_in_data  = 16'h0000;
    settle();
    n_checks++;
    if (status() !== 4'b0100 || bus.in_rdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL in_delayed_c5: status=%b in_rdata=%h expected 0100/beef", status(), bus.in_rdata);
    end
    next_cycle();
    bus.in_req = 1'b0;
    settle();
    n_checks++;
    if (status() !== 4'b0000 || bus.in_rdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL in_delayed_c6: status=%b in_rdata=%h expected 0000/beef", status(), bus.in_rdata);
    end
  endtask

  task automatic test_out_ready();
    logic [3:0] exp_st [4] = '{4'b1000, 4'b1001, 4'b0100, 4'b0000};
    next_cycle();
    bus.ext_out_ready = 1'b1;
    bus.out_req   = 1'b1;
    bus.out_wdata = 16'h1234;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) bus.out_wdata = 16'hDEAD;
      if (c == 3) bus.out_req = 1'b0;
      settle();
      n_checks++;
      if (status() !== exp_st[c]) begin
        n_fail++; $display("FAIL out_ready_c%0d: status=%b expected %b", c, status(), exp_st[c]);
      end
      if (c < 3) next_cycle();
    end
    n_checks++;
    if (bus.ext_out_data !== 16'h1234) begin
      n_fail++; $display("FAIL out_ready_hold: ext_out_data=%h expected 1234", bus.ext_out_data);
    end
  endtask

  task automatic test_priority();
    logic [3:0] exp_st [4] = '{4'b1000, 4'b1001, 4'b0100, 4'b0000};
    logic       ready_seen = 1'b0;
    next_cycle();
    bus.in_req    = 1'b1;
    bus.out_req   = 1'b1;
    bus.out_wdata = 16'h00FF;
    bus.ext_in_valid = 1'b1;
    bus.ext_in_data  = 16'h9999;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        bus.in_req  = 1'b0;
        bus.out_req = 1'b0;
        bus.ext_in_valid = 1'b0;
      end
      settle();
      ready_seen = ready_seen | bus.ext_in_ready;
      n_checks++;
      if (status() !== exp_st[c]) begin
        n_fail++; $display("FAIL priority_c%0d: status=%b expected %b", c, status(), exp_st[c]);
      end
      if (c < 3) next_cycle();
    end
    n_checks++;
    if (ready_seen !== 1'b0 || bus.ext_out_data !== 16'h00FF || bus.in_rdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL priority_result: ready_seen=%b ext_out_data=%h in_rdata=%h expected 0/00ff/beef",
                         ready_seen, bus.ext_out_data, bus.in_rdata);
    end
  endtask

  task automatic test_held_in();
    logic [3:0] exp_st [5] = '{4'b1000, 4'b1010, 4'b0100, 4'b0000, 4'b0000};
    int done_count = 0;
    next_cycle();
    bus.in_req       = 1'b1;
    bus.ext_in_valid = 1'b1;
    bus.ext_in_data  = 16'h3C3C;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) begin
        bus.in_req       = 1'b0;
        bus.ext_in_valid = 1'b0;
      end
      settle();
      if (bus.done === 1'b1) done_count++;
      n_checks++;
      if (status() !== exp_st[c]) begin
        n_fail++; $display("FAIL held_in_c%0d: status=%b expected %b", c, status(), exp_st[c]);
      end
      if (c < 4) next_cycle();
    end
    n_checks++;
    if (done_count != 1 || bus.in_rdata !== 16'h3C3C) begin
      n_fail++; $display("FAIL held_in_once: done_count=%0d in_rdata=%h expected 1/3c3c", done_count, bus.in_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_st [6] = '{4'b1000, 4'b1010, 4'b0100, 4'b1000, 4'b1010, 4'b0100};
    next_cycle();
    bus.in_req       = 1'b1;
    bus.ext_in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.ext_in_data = 16'hA000 + 16'(c);
      settle();
      n_checks++;
      if (status() !== exp_st[c]) begin
        n_fail++; $display("FAIL b2b_c%0d: status=%b expected %b", c, status(), exp_st[c]);
      end
      if (c == 2 || c == 5) begin
        n_checks++;
        if (bus.in_rdata !== ((c == 2) ? 16'hA001 : 16'hA004)) begin
          n_fail++; $display("FAIL b2b_rdata_c%0d: got %h expected %h", c, bus.in_rdata,
                             (c == 2) ? 16'hA001 : 16'hA004);
        end
      end
      next_cycle();
    end
    bus.in_req       = 1'b0;
    bus.ext_in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    next_cycle();
    bus.ext_out_ready = 1'b0;
    bus.out_req   = 1'b1;
    bus.out_wdata = 16'h5A5A;
    settle();
    n_checks++;
    if (status() !== 4'b1000) begin
      n_fail++; $display("FAIL reset_mid_c0: status=%b expected 1000", status());
    end
    next_cycle();
    settle();
    n_checks++;
    if (status() !== 4'b1001 || bus.ext_out_data !== 16'h5A5A) begin
      n_fail++; $display("FAIL reset_mid_c1: status=%b ext_out_data=%h expected 1001/5a5a", status(), bus.ext_out_data);
    end
    next_cycle();
    reset       = 1'b1;
    bus.out_req = 1'b0;
    next_cycle();
    reset = 1'b0;
    settle();
    n_checks++;
    if (status() !== 4'b0000 || bus.ext_out_data !== 16'h0000 || bus.in_rdata !== 16'h0000) begin
      n_fail++; $display("FAIL reset_mid_after: status=%b ext_out_data=%h in_rdata=%h expected 0000/0000/0000",
                         status(), bus.ext_out_data, bus.in_rdata);
    end
    next_cycle();
    settle();
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_no_done: done=%b expected 0", bus.done);
    end
  endtask

`ifdef IO_SEQUENCER_TIMEOUT_EN
  task automatic test_timeout();
    // Load a nonzero word first, so the test can see the timeout force in_rdata to zero.
    next_cycle();
    bus.in_req       = 1'b1;
    bus.ext_in_valid = 1'b1;
    bus.ext_in_data  = 16'h7777;
    next_cycle();
    next_cycle();
    bus.in_req       = 1'b0;
    bus.ext_in_valid = 1'b0;
    settle();
    n_checks++;
    if (bus.in_rdata !== 16'h7777) begin
      n_fail++; $display("FAIL timeout_preload: in_rdata=%h expected 7777", bus.in_rdata);
    end
    next_cycle();
    bus.in_req = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      settle();
      n_checks++;
      if (status() !== ((c == 0) ? 4'b1000 : 4'b1010)) begin
        n_fail++; $display("FAIL timeout_wait_c%0d: status=%b expected %b", c, status(),
                           (c == 0) ? 4'b1000 : 4'b1010);
      end
      next_cycle();
    end
    settle();
    n_checks++;
    if (status() !== 4'b0100 || bus.in_rdata !== 16'h0000 || bus.io_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_done_c6: status=%b in_rdata=%h io_err=%b expected 0100/0000/1",
                         status(), bus.in_rdata, bus.io_err);
    end
    next_cycle();
    bus.in_req = 1'b0;
    next_cycle();
    settle();
    n_checks++;
    if (bus.io_err !== 1'b1 || status() !== 4'b0000) begin
      n_fail++; $display("FAIL timeout_sticky: io_err=%b status=%b expected 1/0000", bus.io_err, status());
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    settle();
    n_checks++;
    if (bus.io_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_reset_clear: io_err=%b expected 0", bus.io_err);
    end
    next_cycle();
    bus.in_req = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      if (c == 5) begin
        bus.ext_in_valid = 1'b1;
        bus.ext_in_data  = 16'h4242;
      end
      settle();
      next_cycle();
    end
    bus.ext_in_valid = 1'b0;
    settle();
    n_checks++;
    if (status() !== 4'b0100 || bus.in_rdata !== 16'h4242 || bus.io_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_race_c6: status=%b in_rdata=%h io_err=%b expected 0100/4242/0",
                         status(), bus.in_rdata, bus.io_err);
    end
    next_cycle();
    bus.in_req = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    int bad_cycles = 0;
    next_cycle();
    bus.in_req = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      next_cycle();
      settle();
      if (status() !== 4'b1010 || bus.io_err !== 1'b0) bad_cycles++;
    end
    n_checks++;
    if (bad_cycles != 0) begin
      n_fail++; $display("FAIL no_timeout_wait: bad_cycles=%0d expected 0", bad_cycles);
    end
    next_cycle();
    bus.ext_in_valid = 1'b1;
    bus.ext_in_data  = 16'h0C0F;
    next_cycle();
    bus.ext_in_valid = 1'b0;
    settle();
    n_checks++;
    if (status() !== 4'b0100 || bus.in_rdata !== 16'h0C0F || bus.io_err !== 1'b0) begin
      n_fail++; $display("FAIL no_timeout_done: status=%b in_rdata=%h io_err=%b expected 0100/0c0f/0",
                         status(), bus.in_rdata, bus.io_err);
    end
    next_cycle();
    bus.in_req = 1'b0;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus.in_req        = 1'b0;
    bus.out_req       = 1'b0;
    bus.out_wdata     = 16'h0000;
    bus.ext_in_data   = 16'h0000;
    bus.ext_in_valid  = 1'b0;
    bus.ext_out_ready = 1'b0;

    test_reset();
    test_in_delayed();
    test_out_ready();
    test_priority();
    test_held_in();
    test_back_to_back();
    test_reset_mid();
`ifdef IO_SEQUENCER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
